// File: rtl/id_pipe.sv
// id_pipe: instruction buffer plus RV32IM decode stage.
// A small FIFO feeds a combinational decoder into a registered EX bundle.
module id_pipe #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter bit CSR_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        inst_addr_i,
  output logic [4:0]             reg1_raddr_o,
  output logic [4:0]             reg2_raddr_o,
  input  logic [XLEN-1:0]        reg1_rdata_i,
  input  logic [XLEN-1:0]        reg2_rdata_i,
  input  logic                   ex_jump_flag_i,
  input  logic                   ex_ld_pending_i,
  input  logic [4:0]             ex_ld_rd_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            inst_o,
  output logic [XLEN-1:0]        inst_addr_o,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic [XLEN-1:0]        op1_jump_o,
  output logic [XLEN-1:0]        op2_jump_o,
  output logic                   reg_we_o,
  output logic [4:0]             reg_waddr_o,
  output logic                   csr_we_o,
  output logic [11:0]            csr_addr_o,
  output logic                   illegal_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] op1_jump;
    logic [XLEN-1:0] op2_jump;
    logic            reg_we;
    logic [4:0]      reg_waddr;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic            illegal;
    logic            is_load;
  } id_ex_t;

  logic [31:0]     r_fifo_inst [DEPTH];
  logic [XLEN-1:0] r_fifo_addr [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  id_ex_t          r_out;
  logic            r_valid;

  logic            w_push;
  logic            w_pop;
  logic            w_head_valid;
  logic [31:0]     w_hinst;
  logic [XLEN-1:0] w_haddr;
  id_ex_t          w_dec;
  logic            w_bad;
  logic            w_rs1_use;
  logic            w_rs2_use;
  logic            w_hz1;
  logic            w_hz2;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign in_ready_o   = (r_count < CW'(DEPTH)) && !ex_jump_flag_i;
  assign w_push       = in_valid_i && in_ready_o;
  assign w_head_valid = (r_count != '0);
  assign w_hinst      = r_fifo_inst[r_rptr];
  assign w_haddr      = r_fifo_addr[r_rptr];

  assign w_opc = w_hinst[6:0];
  assign w_rd  = w_hinst[11:7];
  assign w_f3  = w_hinst[14:12];
  assign w_rs1 = w_hinst[19:15];
  assign w_rs2 = w_hinst[24:20];
  assign w_f7  = w_hinst[31:25];

  assign w_imm_i = {{20{w_hinst[31]}}, w_hinst[31:20]};
  assign w_imm_s = {{20{w_hinst[31]}}, w_hinst[31:25], w_hinst[11:7]};
  assign w_imm_b = {{19{w_hinst[31]}}, w_hinst[31], w_hinst[7],
                    w_hinst[30:25], w_hinst[11:8], 1'b0};
  assign w_imm_u = {w_hinst[31:12], 12'b0};
  assign w_imm_j = {{11{w_hinst[31]}}, w_hinst[31], w_hinst[19:12],
                    w_hinst[20], w_hinst[30:21], 1'b0};

  // Decode the FIFO head into the EX bundle and its source usage.
  always_comb begin
    w_dec      = '0;
    w_dec.inst = w_hinst;
    w_dec.addr = w_haddr;
    w_bad      = 1'b0;
    w_rs1_use  = 1'b0;
    w_rs2_use  = 1'b0;
    unique case (1'b1)
      (w_opc == OPC_LUI): begin
        w_dec.op1       = w_imm_u;
        w_dec.reg_we    = 1'b1;
        w_dec.reg_waddr = w_rd;
      end
      (w_opc == OPC_AUIPC): begin
        w_dec.op1       = w_haddr;
        w_dec.op2       = w_imm_u;
        w_dec.reg_we    = 1'b1;
        w_dec.reg_waddr = w_rd;
      end
      (w_opc == OPC_JAL): begin
        w_dec.op1       = w_haddr;
        w_dec.op2       = XLEN'(4);
        w_dec.op1_jump  = w_haddr;
        w_dec.op2_jump  = w_imm_j;
        w_dec.reg_we    = 1'b1;
        w_dec.reg_waddr = w_rd;
      end
      (w_opc == OPC_JALR): begin
        w_bad           = (w_f3 != 3'b000);
        w_rs1_use       = 1'b1;
        w_dec.op1       = w_haddr;
        w_dec.op2       = XLEN'(4);
        w_dec.op1_jump  = reg1_rdata_i;
        w_dec.op2_jump  = w_imm_i;
        w_dec.reg_we    = 1'b1;
        w_dec.reg_waddr = w_rd;
      end
      (w_opc == OPC_BR): begin
        w_bad          = (w_f3 == 3'b010) || (w_f3 == 3'b011);
        w_rs1_use      = 1'b1;
        w_rs2_use      = 1'b1;
        w_dec.op1      = reg1_rdata_i;
        w_dec.op2      = reg2_rdata_i;
        w_dec.op1_jump = w_haddr;
        w_dec.op2_jump = w_imm_b;
      end
      (w_opc == OPC_LD): begin
        w_bad           = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
        w_rs1_use       = 1'b1;
        w_dec.op1       = reg1_rdata_i;
        w_dec.op2       = w_imm_i;
        w_dec.reg_we    = 1'b1;
        w_dec.reg_waddr = w_rd;
        w_dec.is_load   = 1'b1;
      end
      (w_opc == OPC_ST): begin
        w_bad     = (w_f3 > 3'b010);
        w_rs1_use = 1'b1;
        w_rs2_use = 1'b1;
        w_dec.op1 = reg1_rdata_i;
        w_dec.op2 = w_imm_s;
      end
      (w_opc == OPC_OPIMM): begin
        w_bad = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) &&
                 (w_f7 != 7'b0100000));
        w_rs1_use       = 1'b1;
        w_dec.op1       = reg1_rdata_i;
        w_dec.op2       = w_imm_i;
        w_dec.reg_we    = 1'b1;
        w_dec.reg_waddr = w_rd;
      end
      (w_opc == OPC_OP): begin
        w_rs1_use       = 1'b1;
        w_rs2_use       = 1'b1;
        w_dec.op1       = reg1_rdata_i;
        w_dec.op2       = reg2_rdata_i;
        w_dec.reg_waddr = w_rd;
        if (w_f7 == 7'b0000001) begin
          // Divides finish later in a multicycle unit; EX writes rd then.
          w_dec.reg_we = !w_f3[2];
          if (w_f3[2]) begin
            w_dec.op1_jump = w_haddr;
            w_dec.op2_jump = XLEN'(4);
          end
        end else if (w_f7 == 7'b0000000) begin
          w_dec.reg_we = 1'b1;
        end else if ((w_f7 == 7'b0100000) &&
                     ((w_f3 == 3'b000) || (w_f3 == 3'b101))) begin
          w_dec.reg_we = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      (w_opc == OPC_FENCE): begin
        w_bad          = (w_f3[2:1] != 2'b00);
        w_dec.op1_jump = w_haddr;
        w_dec.op2_jump = XLEN'(4);
      end
      (CSR_EN && (w_opc == OPC_SYS)): begin
        if (w_f3 == 3'b000) begin
          w_bad = !((w_hinst == 32'h00000073) ||
                    (w_hinst == 32'h00100073) ||
                    (w_hinst == 32'h30200073));
        end else if (w_f3 == 3'b100) begin
          w_bad = 1'b1;
        end else begin
          w_dec.csr_we    = 1'b1;
          w_dec.csr_addr  = w_hinst[31:20];
          w_dec.reg_we    = 1'b1;
          w_dec.reg_waddr = w_rd;
          if (!w_f3[2]) begin
            w_rs1_use = 1'b1;
            w_dec.op1 = reg1_rdata_i;
          end else begin
            w_dec.op1 = XLEN'(w_rs1);
          end
        end
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec         = '0;
      w_dec.inst    = w_hinst;
      w_dec.addr    = w_haddr;
      w_dec.illegal = 1'b1;
      w_rs1_use     = 1'b0;
      w_rs2_use     = 1'b0;
    end
  end

  assign reg1_raddr_o = (w_head_valid && w_rs1_use) ? w_rs1 : 5'd0;
  assign reg2_raddr_o = (w_head_valid && w_rs2_use) ? w_rs2 : 5'd0;

  assign w_hz1 = w_rs1_use && (w_rs1 != 5'd0) &&
                 ((ex_ld_pending_i && (w_rs1 == ex_ld_rd_i)) ||
                  (r_valid && r_out.is_load &&
                   (w_rs1 == r_out.reg_waddr)));
  assign w_hz2 = w_rs2_use && (w_rs2 != 5'd0) &&
                 ((ex_ld_pending_i && (w_rs2 == ex_ld_rd_i)) ||
                  (r_valid && r_out.is_load &&
                   (w_rs2 == r_out.reg_waddr)));

  assign w_pop = w_head_valid && (!r_valid || out_ready_i) &&
                 !w_hz1 && !w_hz2 && !ex_jump_flag_i;

  // Buffer storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wptr] <= inst_i;
      r_fifo_addr[r_wptr] <= inst_addr_i;
    end
  end

  // Buffer pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (ex_jump_flag_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Output register: load on pop, drop valid once EX takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (ex_jump_flag_i) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_out   <= w_dec;
      r_valid <= 1'b1;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign inst_o      = r_out.inst;
  assign inst_addr_o = r_out.addr;
  assign op1_o       = r_out.op1;
  assign op2_o       = r_out.op2;
  assign op1_jump_o  = r_out.op1_jump;
  assign op2_jump_o  = r_out.op2_jump;
  assign reg_we_o    = r_out.reg_we;
  assign reg_waddr_o = r_out.reg_waddr;
  assign csr_we_o    = r_out.csr_we;
  assign csr_addr_o  = r_out.csr_addr;
  assign illegal_o   = r_out.illegal;
  assign count_o     = r_count;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed vectors for id_pipe.
// Second instance runs with CSR support disabled.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] addr;
  logic        flush;
  logic        ldp;
  logic [4:0]  ldrd;
  logic        ordy;

  logic        in_ready, b_in_ready;
  logic [4:0]  ra1, ra2, b_ra1, b_ra2;
  logic [31:0] rd1, rd2, b_rd1, b_rd2;
  logic        ovld, b_ovld;
  logic [31:0] inst_o, b_inst_o;
  logic [31:0] iaddr_o, b_iaddr_o;
  logic [31:0] op1, op2, op1j, op2j;
  logic [31:0] b_op1, b_op2, b_op1j, b_op2j;
  logic        we, b_we;
  logic [4:0]  wa, b_wa;
  logic        cwe, b_cwe;
  logic [11:0] caddr, b_caddr;
  logic        ill, b_ill;
  logic [1:0]  cnt, b_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd1   = (ra1 == 5'd0) ? 32'd0 : (32'h1000 | 32'(ra1));
  assign rd2   = (ra2 == 5'd0) ? 32'd0 : (32'h1000 | 32'(ra2));
  assign b_rd1 = (b_ra1 == 5'd0) ? 32'd0 : (32'h1000 | 32'(b_ra1));
  assign b_rd2 = (b_ra2 == 5'd0) ? 32'd0 : (32'h1000 | 32'(b_ra2));

  id_pipe u0 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .inst_addr_i(addr),
    .reg1_raddr_o(ra1), .reg2_raddr_o(ra2),
    .reg1_rdata_i(rd1), .reg2_rdata_i(rd2),
    .ex_jump_flag_i(flush),
    .ex_ld_pending_i(ldp), .ex_ld_rd_i(ldrd),
    .out_valid_o(ovld), .out_ready_i(ordy),
    .inst_o(inst_o), .inst_addr_o(iaddr_o),
    .op1_o(op1), .op2_o(op2),
    .op1_jump_o(op1j), .op2_jump_o(op2j),
    .reg_we_o(we), .reg_waddr_o(wa),
    .csr_we_o(cwe), .csr_addr_o(caddr),
    .illegal_o(ill), .count_o(cnt)
  );

  id_pipe #(.CSR_EN(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .inst_i(inst), .inst_addr_i(addr),
    .reg1_raddr_o(b_ra1), .reg2_raddr_o(b_ra2),
    .reg1_rdata_i(b_rd1), .reg2_rdata_i(b_rd2),
    .ex_jump_flag_i(flush),
    .ex_ld_pending_i(ldp), .ex_ld_rd_i(ldrd),
    .out_valid_o(b_ovld), .out_ready_i(ordy),
    .inst_o(b_inst_o), .inst_addr_o(b_iaddr_o),
    .op1_o(b_op1), .op2_o(b_op2),
    .op1_jump_o(b_op1j), .op2_jump_o(b_op2j),
    .reg_we_o(b_we), .reg_waddr_o(b_wa),
    .csr_we_o(b_cwe), .csr_addr_o(b_caddr),
    .illegal_o(b_ill), .count_o(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] a);
    in_valid = 1'b1;
    inst     = i;
    addr     = a;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; inst = '0; addr = '0;
    flush = 1'b0; ldp = 1'b0; ldrd = '0; ordy = 1'b1;
    #12;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_vld", 32'(ovld), 32'd0);
    chk("rst_op2", op2, 32'd0);

    // ADDI x1,x0,5 right after reset release
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    inst = 32'h00500093; addr = 32'h100;
    #1;
    chk("rel_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("addi_cnt1", 32'(cnt), 32'd1);
    chk("addi_vld0", 32'(ovld), 32'd0);
    tick();
    chk("addi_vld", 32'(ovld), 32'd1);
    chk("addi_op2", op2, 32'd5);
    chk("addi_op1", op1, 32'd0);
    chk("addi_wa", 32'(wa), 32'd1);
    chk("addi_we", 32'(we), 32'd1);
    chk("addi_pc", iaddr_o, 32'h100);
    chk("addi_cnt0", 32'(cnt), 32'd0);
    tick();
    chk("addi_drop", 32'(ovld), 32'd0);

    // JAL x1,+8
    push(32'h008000EF, 32'h200);
    tick();
    chk("jal_op1", op1, 32'h200);
    chk("jal_op2", op2, 32'd4);
    chk("jal_op1j", op1j, 32'h200);
    chk("jal_op2j", op2j, 32'd8);
    chk("jal_we", 32'(we), 32'd1);
    tick();

    // DIV x7,x1,x2
    push(32'h0220C3B3, 32'h240);
    tick();
    chk("div_we", 32'(we), 32'd0);
    chk("div_op1", op1, 32'h1001);
    chk("div_op2", op2, 32'h1002);
    chk("div_op1j", op1j, 32'h240);
    chk("div_op2j", op2j, 32'd4);
    tick();

    // Back-pressure: fill buffer, hold output, then drain
    ordy = 1'b0;
    push(32'h00100093, 32'h300);
    push(32'h00200113, 32'h304);
    push(32'h00300193, 32'h308);
    chk("full_cnt", 32'(cnt), 32'd2);
    chk("full_vld", 32'(ovld), 32'd1);
    chk("full_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b1; inst = 32'h00400213; addr = 32'h30C;
    tick();
    in_valid = 1'b0;
    chk("hold_cnt", 32'(cnt), 32'd2);
    chk("hold_pc", iaddr_o, 32'h300);
    chk("hold_op2", op2, 32'd1);
    ordy = 1'b1;
    tick();
    chk("drn1_pc", iaddr_o, 32'h304);
    chk("drn1_op2", op2, 32'd2);
    chk("drn1_cnt", 32'(cnt), 32'd1);
    tick();
    chk("drn2_pc", iaddr_o, 32'h308);
    chk("drn2_op2", op2, 32'd3);
    chk("drn2_cnt", 32'(cnt), 32'd0);
    tick();
    chk("drn_end", 32'(ovld), 32'd0);

    // Load-use: LW x5 then ADD x6,x5,x1
    push(32'h00012283, 32'h400);
    push(32'h00128333, 32'h404);
    chk("lw_out", inst_o, 32'h00012283);
    chk("lw_wa", 32'(wa), 32'd5);
    chk("hz_ra1", 32'(ra1), 32'd5);
    chk("hz_ra2", 32'(ra2), 32'd1);
    tick();
    chk("hz_vld1", 32'(ovld), 32'd0);
    chk("hz_cnt1", 32'(cnt), 32'd1);
    ldp = 1'b1; ldrd = 5'd5;
    tick();
    chk("hz_vld2", 32'(ovld), 32'd0);
    ldp = 1'b0;
    tick();
    chk("add_vld", 32'(ovld), 32'd1);
    chk("add_inst", inst_o, 32'h00128333);
    chk("add_op1", op1, 32'h1005);
    chk("add_op2", op2, 32'h1001);
    chk("add_cnt", 32'(cnt), 32'd0);
    tick();
    ldrd = 5'd0;

    // Flush with two buffered entries and a same-cycle push
    ordy = 1'b0;
    push(32'h00100093, 32'h500);
    push(32'h00200113, 32'h504);
    push(32'h00300193, 32'h508);
    chk("fl_pre", 32'(cnt), 32'd2);
    flush = 1'b1; in_valid = 1'b1;
    inst = 32'h00500293; addr = 32'h50C;
    #1;
    chk("fl_rdy", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_cnt", 32'(cnt), 32'd0);
    chk("fl_vld", 32'(ovld), 32'd0);
    ordy = 1'b1;
    tick();
    chk("fl_drop", 32'(ovld), 32'd0);

    // Illegal encodings and CSR with support on/off
    push(32'hFFFFFFFF, 32'h600);
    tick();
    chk("ill_vld", 32'(ovld), 32'd1);
    chk("ill_flag", 32'(ill), 32'd1);
    chk("ill_we", 32'(we), 32'd0);
    chk("ill_cwe", 32'(cwe), 32'd0);
    chk("ill_op1", op1, 32'd0);
    tick();
    push(32'h300110F3, 32'h604);
    tick();
    chk("csr_ill", 32'(ill), 32'd0);
    chk("csr_cwe", 32'(cwe), 32'd1);
    chk("csr_we", 32'(we), 32'd1);
    chk("csr_addr", 32'(caddr), 32'h300);
    chk("csr_op1", op1, 32'h1002);
    chk("nocsr_vld", 32'(b_ovld), 32'd1);
    chk("nocsr_ill", 32'(b_ill), 32'd1);
    chk("nocsr_we", 32'(b_we), 32'd0);
    chk("nocsr_cwe", 32'(b_cwe), 32'd0);
    tick();

    // Reset mid-stream
    ordy = 1'b0;
    push(32'h00100093, 32'h700);
    push(32'h00200113, 32'h704);
    chk("mr_pre", 32'(cnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_vld", 32'(ovld), 32'd0);
    chk("mr_cnt", 32'(cnt), 32'd0);
    chk("mr_op2", op2, 32'd0);
    chk("mr_pc", iaddr_o, 32'd0);
    chk("mr_inst", inst_o, 32'd0);
    chk("mr_we", 32'(we), 32'd0);
    @(negedge clk);
    rst = 1'b1; ordy = 1'b1;
    tick();
    chk("mr_cnt2", 32'(cnt), 32'd0);
    chk("mr_vld2", 32'(ovld), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
